// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-path types and constants
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

    // addi x0,x0,0 for bubble insertion downstream
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - DEPTH-entry storage, synchronous write, asynchronous read, no reset
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling FIFO; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    entry_t        wr_entry;
    entry_t        head;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          store;
    logic          deq;

    assign in_ready = rst_n & (cnt != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign count    = cnt;
    assign wr_entry = '{pc: in_pc, inst: in_inst};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rst_n & (cnt == '0) & ~flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid = (cnt != '0);
        out_pc    = '0;
        out_inst  = '0;
        if (bypass) begin
            out_valid = in_valid;
            if (in_valid) begin
                out_pc   = in_pc;
                out_inst = in_inst;
            end
        end else if (cnt != '0) begin
            out_pc   = head.pc;
            out_inst = head.inst;
        end
    end

    assign pop = out_valid & out_ready;
    // A bypassed pop consumes the incoming entry, so nothing is stored or dequeued
    assign store = push & ~(bypass & pop);
    assign deq   = pop & ~bypass;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    fetch_queue_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk   (clk),
        .we    (store & ~flush),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

endmodule
